// File: rtl/bp_pkg.sv
// Shared types for the branch-resolution controller and its prediction queue.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
//
// Contents:
//   ADDR_W       - PC / target width
//   PC_STEP      - fall-through increment for a not-taken branch
//   state_t      - controller FSM states
//   pred_entry_t - one queued fetch prediction {pc, taken, target}
//   fallthru_or_target / is_mispredict - helpers for the resolve compare
package bp_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,   // queue empty
        TRACK   = 2'd1,   // queue holds outstanding predictions
        RECOVER = 2'd2    // cycle after a flush; wrong-path fetch ignored
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
    } pred_entry_t;

    // Correct next fetch PC for a resolved branch. The add wraps modulo
    // 2^ADDR_W, so a not-taken branch at the top of memory falls through to 0.
    function automatic logic [ADDR_W-1:0] fallthru_or_target(
        input logic              taken,
        input logic [ADDR_W-1:0] pc,
        input logic [ADDR_W-1:0] target
    );
        return taken ? target : (pc + PC_STEP);
    endfunction

    // A predicted branch is wrong if the direction differs, or if both say
    // taken but the targets disagree. The target of a not-taken prediction
    // carries no meaning and is never compared.
    function automatic logic is_mispredict(
        input pred_entry_t       pred,
        input logic              act_taken,
        input logic [ADDR_W-1:0] act_target
    );
        return (pred.taken != act_taken) ||
               (pred.taken && act_taken && (pred.target != act_target));
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order circular queue of fetch predictions awaiting resolution.
// Latency: head is combinational from storage; push/pop/clear take effect at the next edge.
// Backpressure: none internally; caller must not push when full unless popping in the same cycle.
//
// Ports:
//   CLK, RESET         - clock, async active-low reset
//   push, wr_entry     - append wr_entry at the tail
//   pop                - drop the head entry
//   clear              - empty the queue; wins over push and pop
//   head               - oldest entry (undefined while empty)
//   count, full, empty - occupancy, decoded from the registered count
module pred_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  pred_entry_t              wr_entry,
    output pred_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pred_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    // Pointers are exactly log2(DEPTH) bits, so they wrap naturally; the
    // extra count bit distinguishes full from empty when rd_ptr == wr_ptr.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    // A push and pop on a full queue write the slot being read this cycle;
    // the read sees the old value because the write lands at the edge.
    always_ff @(posedge CLK) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Matches MEM-stage branch outcomes against queued fetch predictions; drives flush/redirect and predictor training.
// Latency: Flush/Redirect_pc/Upd_* are registered, one cycle after Resolve_valid, one-cycle pulses.
// Backpressure: Stall_fetch while the queue is full; an unpopped push into a full queue is dropped and sets Overflow.
//
// Ports:
//   CLK, RESET                                - clock, async active-low reset
//   Pred_valid/_pc/_taken/_target             - prediction issued at fetch
//   Resolve_valid/_pc/_taken/_target          - actual outcome from MEM
//   Stall_fetch                               - queue full, fetch must hold
//   Flush, Redirect_pc                        - squash younger work and refetch
//   Upd_valid/_pc/_taken/_target/_mispredict  - training update, one per resolve
//   Branch_count, Mispredict_count            - saturating perf counters
//   Overflow                                  - sticky dropped-push flag
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Pred_valid,
    input  logic [31:0]       Pred_pc,
    input  logic              Pred_taken,
    input  logic [31:0]       Pred_target,
    input  logic              Resolve_valid,
    input  logic [31:0]       Resolve_pc,
    input  logic              Resolve_taken,
    input  logic [31:0]       Resolve_target,
    output logic              Stall_fetch,
    output logic              Flush,
    output logic [31:0]       Redirect_pc,
    output logic              Upd_valid,
    output logic [31:0]       Upd_pc,
    output logic              Upd_taken,
    output logic [31:0]       Upd_target,
    output logic              Upd_mispredict,
    output logic [CNT_W-1:0]  Branch_count,
    output logic [CNT_W-1:0]  Mispredict_count,
    output logic              Overflow
);

    localparam int QCNT_W = $clog2(DEPTH) + 1;

    state_t              state_q;
    state_t              state_d;

    pred_entry_t         wr_entry;
    pred_entry_t         head;
    logic [QCNT_W-1:0]   q_count;
    logic                q_full;
    logic                q_empty;

    logic                head_match;
    logic                mispredict;
    logic                pop;
    logic                push_req;
    logic                push_acc;
    logic                push_drop;
    logic [ADDR_W-1:0]   redirect_d;

    // ------------------------------------------------------------------
    // Prediction queue
    // ------------------------------------------------------------------
    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = Pred_pc;
        wr_entry.taken  = Pred_taken;
        wr_entry.target = Pred_target;
    end

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .CLK      (CLK),
        .RESET    (RESET),
        .push     (push_acc),
        .pop      (pop),
        .clear    (mispredict),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // ------------------------------------------------------------------
    // Resolve compare
    // ------------------------------------------------------------------
    // Only the head can match: predictions and resolutions are both in
    // program order. A resolve that misses the head belongs to a branch
    // fetch never predicted, which behaved as not-taken at fetch.
    assign head_match = !q_empty && (head.pc == Resolve_pc);
    assign pop        = Resolve_valid && head_match;

    always_comb begin
        mispredict = 1'b0;
        if (Resolve_valid) begin
            if (head_match) begin
                mispredict = is_mispredict(head, Resolve_taken, Resolve_target);
            end else begin
                mispredict = Resolve_taken;
            end
        end
    end

    assign redirect_d = fallthru_or_target(Resolve_taken, Resolve_pc, Resolve_target);

    // ------------------------------------------------------------------
    // Push qualification
    // ------------------------------------------------------------------
    // During the flush cycle fetch is still on the wrong path, and a push
    // racing a mispredict is younger than the mispredicted branch, so both
    // are discarded. A push into a full queue is still taken when the head
    // pops in the same cycle.
    assign push_req  = Pred_valid && (state_q != RECOVER) && !Flush && !mispredict;
    assign push_acc  = push_req && (!q_full || pop);
    assign push_drop = push_req && q_full && !pop;

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push_acc) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (pop && !push_acc && (q_count == QCNT_W'(1))) begin
                    state_d = IDLE;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A mispredict overrides everything, including a re-flush while
        // already recovering.
        if (mispredict) begin
            state_d = RECOVER;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and counters
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Flush            <= 1'b0;
            Redirect_pc      <= '0;
            Upd_valid        <= 1'b0;
            Upd_pc           <= '0;
            Upd_taken        <= 1'b0;
            Upd_target       <= '0;
            Upd_mispredict   <= 1'b0;
            Branch_count     <= '0;
            Mispredict_count <= '0;
            Overflow         <= 1'b0;
        end else begin
            Flush          <= mispredict;
            Upd_valid      <= Resolve_valid;
            Upd_mispredict <= mispredict;

            // Data fields hold between pulses; consumers qualify them with
            // Flush / Upd_valid.
            if (Resolve_valid) begin
                Redirect_pc <= redirect_d;
                Upd_pc      <= Resolve_pc;
                Upd_taken   <= Resolve_taken;
                Upd_target  <= Resolve_target;
            end

            if (Resolve_valid && (Branch_count != '1)) begin
                Branch_count <= Branch_count + 1'b1;
            end
            if (mispredict && (Mispredict_count != '1)) begin
                Mispredict_count <= Mispredict_count + 1'b1;
            end

            if (push_drop) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Decoded from the registered count, so it rises the cycle after the
    // filling push.
    assign Stall_fetch = q_full;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
module tb_branch_resolve_ctrl;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 6;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic              CLK;
    logic              RESET;
    logic              Pred_valid;
    logic [31:0]       Pred_pc;
    logic              Pred_taken;
    logic [31:0]       Pred_target;
    logic              Resolve_valid;
    logic [31:0]       Resolve_pc;
    logic              Resolve_taken;
    logic [31:0]       Resolve_target;
    logic              Stall_fetch;
    logic              Flush;
    logic [31:0]       Redirect_pc;
    logic              Upd_valid;
    logic [31:0]       Upd_pc;
    logic              Upd_taken;
    logic [31:0]       Upd_target;
    logic              Upd_mispredict;
    logic [CNT_W-1:0]  Branch_count;
    logic [CNT_W-1:0]  Mispredict_count;
    logic              Overflow;

    branch_resolve_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Pred_valid       (Pred_valid),
        .Pred_pc          (Pred_pc),
        .Pred_taken       (Pred_taken),
        .Pred_target      (Pred_target),
        .Resolve_valid    (Resolve_valid),
        .Resolve_pc       (Resolve_pc),
        .Resolve_taken    (Resolve_taken),
        .Resolve_target   (Resolve_target),
        .Stall_fetch      (Stall_fetch),
        .Flush            (Flush),
        .Redirect_pc      (Redirect_pc),
        .Upd_valid        (Upd_valid),
        .Upd_pc           (Upd_pc),
        .Upd_taken        (Upd_taken),
        .Upd_target       (Upd_target),
        .Upd_mispredict   (Upd_mispredict),
        .Branch_count     (Branch_count),
        .Mispredict_count (Mispredict_count),
        .Overflow         (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a plain queue of outstanding predictions plus the
    // outputs expected after the most recent edge.
    // ------------------------------------------------------------------
    pred_entry_t  mq[$];
    logic         m_flush     = 1'b0;
    logic [31:0]  m_redirect  = '0;
    logic         m_upd_valid = 1'b0;
    logic [31:0]  m_upd_pc    = '0;
    logic         m_upd_taken = 1'b0;
    logic [31:0]  m_upd_tgt   = '0;
    logic         m_upd_mis   = 1'b0;
    int           m_bc        = 0;
    int           m_mc        = 0;
    logic         m_ovf       = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mq.delete();
            m_flush = 0; m_redirect = 0; m_upd_valid = 0; m_upd_pc = 0;
            m_upd_taken = 0; m_upd_tgt = 0; m_upd_mis = 0;
            m_bc = 0; m_mc = 0; m_ovf = 0;
        end else begin
            logic was_flush;
            logic mis;
            logic popq;
            was_flush = m_flush;
            mis  = 1'b0;
            popq = 1'b0;
            if (Resolve_valid) begin
                if (mq.size() > 0 && mq[0].pc == Resolve_pc) begin
                    popq = 1'b1;
                    if (mq[0].taken != Resolve_taken)
                        mis = 1'b1;
                    else if (Resolve_taken && mq[0].target != Resolve_target)
                        mis = 1'b1;
                end else begin
                    mis = Resolve_taken;
                end
                m_redirect  = Resolve_taken ? Resolve_target : Resolve_pc + 32'd4;
                m_upd_pc    = Resolve_pc;
                m_upd_taken = Resolve_taken;
                m_upd_tgt   = Resolve_target;
                m_bc++;
                if (mis) m_mc++;
            end
            if (popq) void'(mq.pop_front());
            if (mis) begin
                mq.delete();
            end else if (Pred_valid && !was_flush) begin
                if (mq.size() < DEPTH) begin
                    pred_entry_t e;
                    e.pc = Pred_pc; e.taken = Pred_taken; e.target = Pred_target;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_flush     = mis;
            m_upd_valid = Resolve_valid;
            m_upd_mis   = mis;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("stall_fetch", Stall_fetch, (mq.size() == DEPTH));
        chk("flush", Flush, m_flush);
        if (m_flush) chk("redirect_pc", Redirect_pc, m_redirect);
        chk("upd_valid", Upd_valid, m_upd_valid);
        if (m_upd_valid) begin
            chk("upd_pc", Upd_pc, m_upd_pc);
            chk("upd_taken", Upd_taken, m_upd_taken);
            chk("upd_target", Upd_target, m_upd_tgt);
        end
        chk("upd_mispredict", Upd_mispredict, m_upd_mis);
        chk("branch_count", Branch_count, (m_bc > MAXC) ? MAXC : m_bc);
        chk("mispredict_count", Mispredict_count, (m_mc > MAXC) ? MAXC : m_mc);
        chk("overflow", Overflow, m_ovf);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtg);
        Pred_valid = pv; Pred_pc = ppc; Pred_taken = pt; Pred_target = ptg;
        Resolve_valid = rv; Resolve_pc = rpc; Resolve_taken = rt; Resolve_target = rtg;
        @(posedge CLK);
        #1;
        Pred_valid = 1'b0;
        Resolve_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        cyc(1'b1, pc, t, tg, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, t, tg);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, Stall_fetch, 0);
        chk({tag, "_flush"}, Flush, 0);
        chk({tag, "_redirect"}, Redirect_pc, 0);
        chk({tag, "_upd_valid"}, Upd_valid, 0);
        chk({tag, "_upd_pc"}, Upd_pc, 0);
        chk({tag, "_upd_taken"}, Upd_taken, 0);
        chk({tag, "_upd_target"}, Upd_target, 0);
        chk({tag, "_upd_mis"}, Upd_mispredict, 0);
        chk({tag, "_bcount"}, Branch_count, 0);
        chk({tag, "_mcount"}, Mispredict_count, 0);
        chk({tag, "_overflow"}, Overflow, 0);
    endtask

    int n_res;

    initial begin
        RESET = 1'b0;
        Pred_valid = 0; Pred_pc = 0; Pred_taken = 0; Pred_target = 0;
        Resolve_valid = 0; Resolve_pc = 0; Resolve_taken = 0; Resolve_target = 0;
        #1;
        chk_all_zero("reset");
        idle(2);
        RESET = 1'b1;
        idle(1);

        // Correctly predicted taken branch
        push(32'h100, 1'b1, 32'h200);
        resolve(32'h100, 1'b1, 32'h200);
        chk("ok_upd_valid", Upd_valid, 1);
        chk("ok_upd_mis", Upd_mispredict, 0);
        chk("ok_flush", Flush, 0);
        chk("ok_bcount", Branch_count, 1);
        chk("ok_upd_pc", Upd_pc, 32'h100);

        // Direction mispredict clears the younger entry
        push(32'h100, 1'b0, 32'h0);
        push(32'h104, 1'b1, 32'h300);
        resolve(32'h100, 1'b1, 32'h180);
        chk("dir_flush", Flush, 1);
        chk("dir_redirect", Redirect_pc, 32'h180);
        chk("dir_mcount", Mispredict_count, 1);
        // Resolving the discarded 0x104 in the recovery cycle finds no entry
        resolve(32'h104, 1'b1, 32'h300);
        chk("recov_flush", Flush, 1);
        chk("recov_redirect", Redirect_pc, 32'h300);
        chk("recov_mcount", Mispredict_count, 2);
        idle(1);

        // Target mispredict and taken-predicted-but-fell-through
        push(32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b1, 32'h90);
        chk("tgt_flush", Flush, 1);
        chk("tgt_redirect", Redirect_pc, 32'h90);
        idle(1);
        push(32'h40, 1'b1, 32'h80);
        resolve(32'h40, 1'b0, 32'hdead);
        chk("nt_redirect", Redirect_pc, 32'h44);
        chk("nt_upd_mis", Upd_mispredict, 1);
        idle(1);
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
        chk("wrap_flush", Flush, 1);
        chk("wrap_redirect", Redirect_pc, 32'h0);
        idle(1);

        // Fill, overflow, and push+pop at full
        push(32'h1000, 1'b0, 32'h0);
        push(32'h1004, 1'b0, 32'h0);
        push(32'h1008, 1'b0, 32'h0);
        chk("fill3_stall", Stall_fetch, 0);
        push(32'h100c, 1'b0, 32'h0);
        chk("fill4_stall", Stall_fetch, 1);
        chk("fill4_ovf", Overflow, 0);
        push(32'h1010, 1'b0, 32'h0);
        chk("ovf_set", Overflow, 1);
        chk("ovf_stall", Stall_fetch, 1);
        cyc(1'b1, 32'h1014, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0, 32'h0);
        chk("pushpop_stall", Stall_fetch, 1);
        chk("pushpop_flush", Flush, 0);
        resolve(32'h1004, 1'b0, 32'h0);
        chk("drain_stall", Stall_fetch, 0);
        chk("ovf_sticky", Overflow, 1);
        resolve(32'h9999_0000, 1'b1, 32'h2000);
        idle(1);

        // Unpredicted branches with an empty queue
        resolve(32'h500, 1'b1, 32'h600);
        chk("unp_flush", Flush, 1);
        chk("unp_redirect", Redirect_pc, 32'h600);
        idle(1);
        resolve(32'h500, 1'b0, 32'h0);
        chk("unp_nt_flush", Flush, 0);
        chk("unp_nt_upd_valid", Upd_valid, 1);
        chk("unp_nt_upd_mis", Upd_mispredict, 0);

        // Reset while a flush pulse is visible
        push(32'h700, 1'b1, 32'h800);
        resolve(32'h700, 1'b1, 32'h880);
        chk("pre_rst_flush", Flush, 1);
        RESET = 1'b0;
        #1;
        chk_all_zero("midrst");
        idle(2);
        RESET = 1'b1;
        idle(1);

        // Randomised traffic against the model
        n_res = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        pv, pt, rv, rt;
            logic [31:0] ppc, ptg, rpc, rtg;
            pv  = ($urandom_range(0, 2) != 0);
            ppc = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
            pt  = $urandom_range(0, 1);
            ptg = 32'h3000 + 32'($urandom_range(0, 7)) * 4;
            rv  = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rpc = mq[0].pc;
                rt  = ($urandom_range(0, 7) != 0) ? mq[0].taken : ~mq[0].taken;
                rtg = ($urandom_range(0, 7) != 0) ? mq[0].target : 32'h3000 + 32'($urandom_range(0, 7)) * 4;
            end else begin
                rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'h2000 + 32'($urandom_range(0, 15)) * 4;
                rt  = $urandom_range(0, 1);
                rtg = 32'h3000 + 32'($urandom_range(0, 7)) * 4;
            end
            if (c == 1500) begin
                RESET = 1'b0;
                idle(2);
                RESET = 1'b1;
                n_res = 0;
            end
            if (rv) n_res++;
            cyc(pv, ppc, pt, ptg, rv, rpc, rt, rtg);
        end
        idle(2);
        if (n_res > MAXC) chk("bcount_saturated", Branch_count, MAXC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
